// File: rtl/sdram_burst_arbiter.sv
// Round-robin arbiter that shares one SDRAM port between two block-transfer
// requesters and sequences one fixed-length burst per grant.
module sdram_burst_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int OFFSET_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                wr_rd0,
    input  logic [ADDR_W-1:0]   base_addr0,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic                req1,
    input  logic                wr_rd1,
    input  logic [ADDR_W-1:0]   base_addr1,
    input  logic [DATA_W-1:0]   wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic [OFFSET_W-1:0] xfer_offset,
    output logic [DATA_W-1:0]   rdata,
    output logic                rdata_valid,
    output logic [ADDR_W-1:0]   sdram_addr,
    output logic                sdram_wr_rd,
    output logic [DATA_W-1:0]   sdram_din,
    input  logic [DATA_W-1:0]   sdram_dout,
    output logic                memstrb
);

    typedef enum logic [2:0] {IDLE, GRANT, SETUP, STRB, DONE} state_t;

    localparam logic [OFFSET_W-1:0] LAST_OFF = '1;

    state_t                     state;
    logic                       owner;
    logic                       last_grant;
    logic                       dir;
    logic [ADDR_W-OFFSET_W-1:0] base;
    logic                       pick;
    logic [OFFSET_W-1:0]        next_off;
    logic                       unused_low;

    // Under contention the requester that did not win last time goes next.
    assign pick       = (req0 & req1) ? ~last_grant : req1;
    assign next_off   = xfer_offset + 1'b1;
    assign unused_low = ^{base_addr0[OFFSET_W-1:0], base_addr1[OFFSET_W-1:0]};

    always_comb begin
        sdram_din = '0;
        if (state != IDLE)
            sdram_din = owner ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            dir         <= 1'b0;
            base        <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            xfer_offset <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            sdram_addr  <= '0;
            sdram_wr_rd <= 1'b0;
            memstrb     <= 1'b0;
        end else begin
            done0       <= 1'b0;
            done1       <= 1'b0;
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state       <= GRANT;
                        owner       <= pick;
                        last_grant  <= pick;
                        gnt0        <= ~pick;
                        gnt1        <= pick;
                        dir         <= pick ? wr_rd1 : wr_rd0;
                        base        <= pick ? base_addr1[ADDR_W-1:OFFSET_W]
                                            : base_addr0[ADDR_W-1:OFFSET_W];
                        xfer_offset <= '0;
                    end
                end
                GRANT: begin
                    state       <= SETUP;
                    sdram_addr  <= {base, xfer_offset};
                    sdram_wr_rd <= dir;
                    memstrb     <= 1'b0;
                end
                SETUP: begin
                    state   <= STRB;
                    memstrb <= 1'b1;
                end
                STRB: begin
                    memstrb <= 1'b0;
                    if (!dir) begin
                        rdata       <= sdram_dout;
                        rdata_valid <= 1'b1;
                    end
                    if (xfer_offset == LAST_OFF) begin
                        state       <= DONE;
                        gnt0        <= 1'b0;
                        gnt1        <= 1'b0;
                        done0       <= ~owner;
                        done1       <= owner;
                        sdram_wr_rd <= 1'b0;
                        xfer_offset <= '0;
                    end else begin
                        state       <= SETUP;
                        xfer_offset <= next_off;
                        sdram_addr  <= {base, next_off};
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Bench for sdram_burst_arbiter: burst-timeline model checked every cycle,
// SDRAM memory model, and directed scenarios with hand-computed expectations.
module tb_sdram_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, wr_rd0 = 1'b0, req1 = 1'b0, wr_rd1 = 1'b0;
    logic [15:0] base_addr0 = '0, base_addr1 = '0;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, rdata_valid, sdram_wr_rd, memstrb;
    logic [3:0]  xfer_offset;
    logic [7:0]  rdata, sdram_din, sdram_dout;
    logic [15:0] sdram_addr;

    always #5 clk = ~clk;

    sdram_burst_arbiter #(.ADDR_W(16), .DATA_W(8), .OFFSET_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wr_rd0(wr_rd0), .base_addr0(base_addr0), .wdata0(wdata0),
        .req1(req1), .wr_rd1(wr_rd1), .base_addr1(base_addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .xfer_offset(xfer_offset), .rdata(rdata), .rdata_valid(rdata_valid),
        .sdram_addr(sdram_addr), .sdram_wr_rd(sdram_wr_rd), .sdram_din(sdram_din),
        .sdram_dout(sdram_dout), .memstrb(memstrb)
    );

    // Requesters present offset-tagged write words.
    assign wdata0 = 8'h30 + {4'h0, xfer_offset};
    assign wdata1 = 8'hA0 + {4'h0, xfer_offset};

    // SDRAM model: preloaded pattern, written on strobe when direction is write.
    logic [7:0] mem [0:65535];
    bit         mem_ready;
    assign sdram_dout = mem[sdram_addr];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++)
                mem[i] <= 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
            mem_ready <= 1'b1;
        end else if (memstrb && sdram_wr_rd) begin
            mem[sdram_addr] <= sdram_din;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: each burst is a 34-cycle timeline t=0..33 starting at the grant.
    bit         m_busy, m_own, m_dir, m_last;
    int         m_t;
    logic [11:0] m_base;
    logic       m_pick;
    assign m_pick = (req0 && req1) ? !m_last : req1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            m_last <= 1'b1;
        end else if (m_busy) begin
            if (m_t == 33) m_busy <= 1'b0;
            m_t <= m_t + 1;
        end else if (req0 || req1) begin
            m_busy <= 1'b1;
            m_t    <= 0;
            m_own  <= m_pick;
            m_last <= m_pick;
            m_dir  <= m_pick ? wr_rd1 : wr_rd0;
            m_base <= m_pick ? base_addr1[15:4] : base_addr0[15:4];
        end
    end

    task automatic compare_cycle();
        bit         b     = m_busy;
        int         t     = m_t;
        bit         hold  = b && t <= 32;
        bit         strb  = b && t >= 2 && t <= 32 && (t % 2 == 0);
        bit         rv    = b && !m_dir && t >= 3 && t <= 33 && (t % 2 == 1);
        logic [3:0] off   = (b && t >= 3 && t <= 32) ? 4'((t - 1) / 2) : 4'h0;
        logic [7:0] din_e = !b ? 8'h00 : (m_own ? 8'hA0 + {4'h0, off} : 8'h30 + {4'h0, off});
        chk("gnt0", gnt0, hold && !m_own);
        chk("gnt1", gnt1, hold && m_own);
        chk("done0", done0, b && t == 33 && !m_own);
        chk("done1", done1, b && t == 33 && m_own);
        chk("memstrb", memstrb, strb);
        chk("xfer_offset", xfer_offset, off);
        chk("sdram_wr_rd", sdram_wr_rd, b && t >= 1 && t <= 32 && m_dir);
        chk("rdata_valid", rdata_valid, rv);
        chk("sdram_din", sdram_din, din_e);
        if (b && t >= 1 && t <= 33)
            chk("sdram_addr", sdram_addr, {m_base, (t == 33) ? 4'hF : off});
        if (rv)
            chk("rdata", rdata, mem[{m_base, 4'((t - 3) / 2)}]);
    endtask

    // Per-cycle compare plus event logs for the directed checks.
    logic [15:0] addr_q[$];
    int          gq[$];
    int          rv_cnt = 0;
    logic        pg0 = 1'b0, pg1 = 1'b0;
    always @(negedge clk) begin
        compare_cycle();
        if (memstrb) addr_q.push_back(sdram_addr);
        if (rdata_valid) rv_cnt <= rv_cnt + 1;
        if (gnt0 && !pg0) gq.push_back(0);
        if (gnt1 && !pg1) gq.push_back(1);
        pg0 <= gnt0;
        pg1 <= gnt1;
    end

    function automatic logic sel(input int which);
        case (which)
            0:       return gnt0;
            1:       return gnt1;
            2:       return done0;
            default: return done1;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int start, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (sel(which)) begin
                at = cyc - start;
                break;
            end
        end
    endtask

    initial begin
        int start, at, q0, r0, g0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst gnt0", gnt0, 0);
        chk("rst gnt1", gnt1, 0);
        chk("rst memstrb", memstrb, 0);
        chk("rst xfer_offset", xfer_offset, 0);
        chk("rst sdram_addr", sdram_addr, 0);
        chk("rst rdata", rdata, 0);
        chk("rst rdata_valid", rdata_valid, 0);
        chk("rst sdram_din", sdram_din, 0);

        // 1: read burst for requester 0
        rst = 1'b0; req0 = 1'b1; wr_rd0 = 1'b0; base_addr0 = 16'h12A7;
        start = cyc; q0 = addr_q.size(); r0 = rv_cnt;
        wait_sig(0, start, at); chk("t1 gnt0 cycle", at, 1);
        wait_sig(2, start, at); chk("t1 done0 cycle", at, 34);
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t1 strobes", addr_q.size() - q0, 16);
        chk("t1 rdata_valid count", rv_cnt - r0, 16);
        chk("t1 first addr", addr_q[q0], 16'h12A0);
        chk("t1 last addr", addr_q[q0 + 15], 16'h12AF);

        // 2: write burst for requester 1
        req1 = 1'b1; wr_rd1 = 1'b1; base_addr1 = 16'h0040;
        start = cyc; q0 = addr_q.size(); r0 = rv_cnt;
        wait_sig(3, start, at); chk("t2 done1 cycle", at, 34);
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t2 strobes", addr_q.size() - q0, 16);
        chk("t2 rdata_valid count", rv_cnt - r0, 0);
        for (int i = 0; i < 16; i++)
            chk("t2 mem", mem[16'h0040 + 16'(i)], 8'hA0 + 8'(i));

        // 3: simultaneous requests after reset, then continuous contention
        rst = 1'b1; #2;
        @(posedge clk); #1;
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; wr_rd0 = 1'b0; wr_rd1 = 1'b0;
        base_addr0 = 16'h2000; base_addr1 = 16'h3000;
        g0 = gq.size();
        for (int i = 0; i < 400 && gq.size() - g0 < 4; i++) begin
            @(posedge clk); #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("t3 grant count", gq.size() - g0, 4);
        for (int i = 0; i < 4 && g0 + i < gq.size(); i++)
            chk("t3 grant order", gq[g0 + i], i % 2);
        wait_sig(3, cyc, at);
        repeat (3) @(posedge clk);
        #1;

        // 4: reset in the middle of a burst, then restart
        req0 = 1'b1; wr_rd0 = 1'b0; base_addr0 = 16'h1234;
        start = cyc;
        repeat (10) @(posedge clk);
        #1;
        chk("t4 offset before rst", xfer_offset, 4);
        rst = 1'b1; #1;
        chk("t4 gnt0", gnt0, 0);
        chk("t4 done0", done0, 0);
        chk("t4 memstrb", memstrb, 0);
        chk("t4 xfer_offset", xfer_offset, 0);
        chk("t4 sdram_addr", sdram_addr, 0);
        chk("t4 sdram_wr_rd", sdram_wr_rd, 0);
        chk("t4 rdata", rdata, 0);
        chk("t4 rdata_valid", rdata_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start = cyc; q0 = addr_q.size();
        wait_sig(0, start, at); chk("t4 gnt0 cycle", at, 1);
        wait_sig(2, start, at); chk("t4 done0 cycle", at, 34);
        req0 = 1'b0;
        chk("t4 restart addr", addr_q[q0], 16'h1230);
        repeat (3) @(posedge clk);
        #1;

        // 5: base/direction/req changes mid-burst are ignored
        req0 = 1'b1; wr_rd0 = 1'b0; base_addr0 = 16'h5550;
        start = cyc; q0 = addr_q.size(); r0 = rv_cnt;
        wait_sig(0, start, at);
        repeat (4) @(posedge clk);
        #1;
        base_addr0 = 16'hFFFF; wr_rd0 = 1'b1; req0 = 1'b0;
        wait_sig(2, start, at); chk("t5 done0 cycle", at, 34);
        repeat (3) @(posedge clk);
        #1;
        chk("t5 last addr", addr_q[q0 + 15], 16'h555F);
        chk("t5 rdata_valid count", rv_cnt - r0, 16);
        chk("t5 no regrant", gnt0, 0);

        // 6: req held after done gives a second grant at done+2
        req0 = 1'b1; wr_rd0 = 1'b0; base_addr0 = 16'h0100;
        start = cyc;
        wait_sig(2, start, at); chk("t6 done0 cycle", at, 34);
        wait_sig(0, start, at); chk("t6 regrant cycle", at, 36);
        req0 = 1'b0;
        wait_sig(2, start, at); chk("t6 second done0", at, 69);
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
